cp0_irq: RTL and testbench
==========================

Name: cp0_irq

Overview:
Parametrised coprocessor-0 for the pipelined MIPS core. It supports N_IRQ external interrupt lines, each edge-detected into a pending bit, with per-line masking, fixed priority and optional vectored dispatch. It holds the STATUS, CAUSE, EPC and EHBR registers, services MFC0/MTC0/ERET, and drives the PC-override jump.
- Reads: ID stage.
- Writes and ERET: EXE stage.
- Interrupt decision: MEM stage.

Parameters:
N_IRQ, 4, number of interrupt lines (1..8)
VEC_STRIDE, 32'h20, byte spacing between vectored handler entries
EHBR_RST, 32'h0000_0000, reset value of EHBR

Ports:
clk  in  1  main clock, all state on posedge
rst  in  1  asynchronous active-high reset
oper  in  2  00 none, 01 MFC0, 10 MTC0, 11 ERET
addr_r  in  5  read register address
data_r  out  32  combinational read data
addr_w  in  5  write register address
data_w  in  32  write data (CPR[rt])
ir_en  in  1  pipeline permits taking an interrupt this cycle
ir_in  in  N_IRQ  external interrupt lines, synchronous to clk
ret_addr  in  32  PC saved to EPC on interrupt
jump_en  out  1  registered one-cycle PC-override pulse
jump_addr  out  32  registered target address
ir  out  1  registered one-cycle "interrupt taken" pulse
ir_busy  out  1  equals STATUS.EXL (handler active)
ir_pending  out  N_IRQ  current CAUSE.IP bits

Behaviour:
Register map (all other addresses read 0; writes to them are ignored):
- 12 STATUS: bit0 IE, bit1 EXL, bit2 VE, bits[8+N_IRQ-1:8] IM; other bits read 0.
- 13 CAUSE: bits[8+N_IRQ-1:8] IP, bits[6:2] CODE (taken line index); other bits 0.
- 14 EPC: full 32-bit read/write.
- 15 EHBR: full 32-bit read/write; bits[1:0] are forced to 0.

Reset (async, while rst=1):
- STATUS: IE=1, EXL=0, VE=0, IM all ones.
- CAUSE = 0; EPC = 0; EHBR = EHBR_RST.
- Edge-detect flops = 0.
- jump_en = 0, jump_addr = 0, ir = 0.
- A line already high when reset releases therefore registers an edge on the first clock.

Pending logic:
- prev[i] <= ir_in[i] on every clock.
- IP[i] is set when ir_in[i] & ~prev[i].
- IP[i] is cleared by MTC0 to CAUSE with data_w[8+i]=1 (write-one-to-clear), or when line i is taken.
- A set in the same cycle as a clear wins: IP stays 1.

Take condition:
- take = ir_en & IE & ~EXL & ~eret & |(IP & IM).
- Selected line k is the lowest-index set bit of IP & IM.

On take (at posedge):
- EPC <= ret_addr; EXL <= 1; CODE <= k; IP[k] cleared.
- ir <= 1; jump_en <= 1.
- jump_addr <= EHBR + k*VEC_STRIDE if VE=1, else EHBR.
- Latency: ir_in edge at posedge n gives IP set after posedge n. Take is evaluated in cycle n+1, so jump_en is high in cycle n+2.

ERET (oper=11):
- EXL <= 0; jump_en <= 1; jump_addr <= EPC (value before this edge).
- ERET has priority over take in the same cycle. The interrupt is taken no earlier than the next cycle.

MTC0 (oper=10):
- Writes the addressed register at posedge; CAUSE CODE bits and read-only bits are unaffected.
- If take occurs in the same cycle, take updates win for EPC, STATUS.EXL and the CAUSE fields. The remaining written bits still commit.

Other cycles:
- jump_en <= 0, jump_addr <= 0, ir <= 0. The pulses are exactly one cycle long.

Read path:
- data_r is the pre-edge register contents. A same-cycle MTC0 to addr_r is not forwarded.

Nesting:
- While EXL=1, no take occurs. Edges keep accumulating in IP and are serviced after ERET, in priority order.

Test Plan:
1. Reset, EHBR=0x100, VE=0; pulse ir_in[2] with ir_en=1, ret_addr=0x40 -> two cycles after the edge: jump_en=1 for one cycle, jump_addr=0x100, EPC=0x40, CODE=2, EXL=1, IP[2]=0.
2. VE=1, VEC_STRIDE=0x20, EHBR=0x200; raise ir_in[3] and ir_in[1] in the same cycle -> line 1 taken first, jump_addr=0x220. ERET then gives jump_addr=EPC; line 3 is taken next with jump_addr=0x260.
3. IM[0]=0; pulse ir_in[0] -> IP[0]=1, no take. Then MTC0 CAUSE data_w=0x100 -> IP[0]=0, still no jump.
4. ERET and a pending unmasked line in the same cycle -> jump_addr=EPC; the interrupt jump follows on the next allowed cycle, and EPC is then overwritten with the new ret_addr.
5. Hold ir_in[0] high with EXL=1 -> IP[0] set once; it does not re-set while the line stays high, and a second edge is required after the clear.
6. Assert rst mid-handler (EXL=1, jump_en=1) -> all outputs and registers return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/cp0_irq.sv
// Coprocessor 0 for the pipelined MIPS core: STATUS/CAUSE/EPC/EHBR registers and
// edge-triggered interrupt lines with masking, fixed priority and optional vectored dispatch.
module cp0_irq #(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_STRIDE = 32'h20,
    parameter logic [31:0] EHBR_RST   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] ir_in,
    input  logic [31:0]      ret_addr,
    output logic             jump_en,
    output logic [31:0]      jump_addr,
    output logic             ir,
    output logic             ir_busy,
    output logic [N_IRQ-1:0] ir_pending
);
    typedef enum logic [1:0] {OP_NONE, OP_MFC0, OP_MTC0, OP_ERET} oper_e;

    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;
    localparam logic [4:0] A_EHBR   = 5'd15;

    logic             ie, exl, ve;
    logic [N_IRQ-1:0] im, ip, prev;
    logic [4:0]       code;
    logic [31:0]      epc, ehbr;

    oper_e            op;
    logic             is_mtc0, is_eret, take;
    logic [N_IRQ-1:0] masked, take_mask, ip_next;
    logic [2:0]       k;
    logic [31:0]      vec_addr;

    assign op         = oper_e'(oper);
    assign is_mtc0    = (op == OP_MTC0);
    assign is_eret    = (op == OP_ERET);
    assign masked     = ip & im;
    assign take_mask  = masked & (~masked + 1'b1);
    assign take       = ir_en & ie & ~exl & ~is_eret & (|masked);
    assign vec_addr   = ehbr + ({29'b0, k} * VEC_STRIDE);
    assign ir_busy    = exl;
    assign ir_pending = ip;

    // Lowest-index unmasked pending line has priority
    always_comb begin
        k = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) k = 3'(i);
        end
    end

    // New edges override a same-cycle write-one-to-clear or take-clear
    always_comb begin
        ip_next = ip;
        if (is_mtc0 && addr_w == A_CAUSE) ip_next = ip_next & ~data_w[8 +: N_IRQ];
        if (take) ip_next = ip_next & ~take_mask;
        ip_next = ip_next | (ir_in & ~prev);
    end

    always_comb begin
        data_r = '0;
        case (addr_r)
            A_STATUS: begin
                data_r[0]          = ie;
                data_r[1]          = exl;
                data_r[2]          = ve;
                data_r[8 +: N_IRQ] = im;
            end
            A_CAUSE: begin
                data_r[8 +: N_IRQ] = ip;
                data_r[6:2]        = code;
            end
            A_EPC:   data_r = epc;
            A_EHBR:  data_r = ehbr;
            default: data_r = '0;
        endcase
    end

    // Take updates are placed last so they override a same-cycle MTC0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie        <= 1'b1;
            exl       <= 1'b0;
            ve        <= 1'b0;
            im        <= '1;
            ip        <= '0;
            prev      <= '0;
            code      <= '0;
            epc       <= '0;
            ehbr      <= EHBR_RST;
            jump_en   <= 1'b0;
            jump_addr <= '0;
            ir        <= 1'b0;
        end else begin
            prev      <= ir_in;
            ip        <= ip_next;
            jump_en   <= 1'b0;
            jump_addr <= '0;
            ir        <= 1'b0;
            if (is_mtc0 && addr_w == A_STATUS) begin
                ie  <= data_w[0];
                exl <= data_w[1];
                ve  <= data_w[2];
                im  <= data_w[8 +: N_IRQ];
            end
            if (is_mtc0 && addr_w == A_EPC) epc <= data_w;
            if (is_mtc0 && addr_w == A_EHBR) ehbr <= {data_w[31:2], 2'b00};
            if (is_eret) begin
                exl       <= 1'b0;
                jump_en   <= 1'b1;
                jump_addr <= epc;
            end else if (take) begin
                exl       <= 1'b1;
                epc       <= ret_addr;
                code      <= {2'b00, k};
                ir        <= 1'b1;
                jump_en   <= 1'b1;
                jump_addr <= ve ? vec_addr : ehbr;
            end
        end
    end
endmodule

// File: tb/tb_cp0_irq.sv
// Testbench for cp0_irq: randomized register/interrupt traffic against a register-level
// reference model, with jump pulses checked through a scoreboard queue.
module tb_cp0_irq;
    localparam int          N         = 4;
    localparam logic [31:0] STRIDE    = 32'h20;
    localparam logic [31:0] EHBR_INIT = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    oper;
    logic [4:0]    addr_r, addr_w;
    logic [31:0]   data_r, data_w;
    logic          ir_en;
    logic [N-1:0]  ir_in;
    logic [31:0]   ret_addr;
    logic          jump_en;
    logic [31:0]   jump_addr;
    logic          ir, ir_busy;
    logic [N-1:0]  ir_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        ir;
    } exp_t;
    exp_t sb[$];

    bit          m_ie, m_exl, m_ve;
    bit          m_im[N];
    bit          m_ip[N];
    bit          m_prev[N];
    int          m_code;
    logic [31:0] m_epc, m_ehbr;

    cp0_irq #(.N_IRQ(N), .VEC_STRIDE(STRIDE), .EHBR_RST(EHBR_INIT)) dut (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .ir(ir),
        .ir_busy(ir_busy), .ir_pending(ir_pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic void modelReset();
        m_ie = 1; m_exl = 0; m_ve = 0; m_code = 0;
        m_epc = 0; m_ehbr = EHBR_INIT;
        for (int i = 0; i < N; i++) begin
            m_im[i] = 1; m_ip[i] = 0; m_prev[i] = 0;
        end
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        logic [31:0] w = 0;
        case (a)
            12: begin
                w = (m_ie ? 1 : 0) + (m_exl ? 2 : 0) + (m_ve ? 4 : 0);
                for (int i = 0; i < N; i++) if (m_im[i]) w += 32'(1) << (8 + i);
            end
            13: begin
                w = 32'(m_code) << 2;
                for (int i = 0; i < N; i++) if (m_ip[i]) w += 32'(1) << (8 + i);
            end
            14: w = m_epc;
            15: w = m_ehbr;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic logic [N-1:0] modelPending();
        logic [N-1:0] p = 0;
        for (int i = 0; i < N; i++) p[i] = m_ip[i];
        return p;
    endfunction

    // Advance the model across the next clock edge and queue any jump it implies
    task automatic stepModel(input logic [1:0] op, input logic [4:0] aw, input logic [31:0] dw,
                             input logic en, input logic [N-1:0] lines, input logic [31:0] ra);
        int   k = -1;
        bit   take, eret, wr, rise, clr;
        bit   nip[N];
        exp_t e;
        eret = (op == 2'b11);
        wr   = (op == 2'b10);
        for (int i = N - 1; i >= 0; i--) if (m_ip[i] && m_im[i]) k = i;
        take = en && m_ie && !m_exl && !eret && (k >= 0);
        e.cyc = cyc + 1;
        if (eret) begin
            e.addr = m_epc; e.ir = 0; sb.push_back(e);
        end else if (take) begin
            e.addr = m_ve ? m_ehbr + 32'(k) * STRIDE : m_ehbr; e.ir = 1; sb.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            rise   = lines[i] && !m_prev[i];
            clr    = (wr && aw == 13 && dw[8 + i]) || (take && i == k);
            nip[i] = rise || (m_ip[i] && !clr);
        end
        if (wr && aw == 12) begin
            m_ie = dw[0]; m_exl = dw[1]; m_ve = dw[2];
            for (int i = 0; i < N; i++) m_im[i] = dw[8 + i];
        end
        if (wr && aw == 14) m_epc = dw;
        if (wr && aw == 15) m_ehbr = dw & ~32'h3;
        if (eret) m_exl = 0;
        if (take) begin
            m_exl = 1; m_epc = ra; m_code = k;
        end
        for (int i = 0; i < N; i++) begin
            m_ip[i] = nip[i]; m_prev[i] = lines[i];
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] aw, input logic [31:0] dw,
                                 input logic [4:0] ar, input logic en, input logic [N-1:0] lines,
                                 input logic [31:0] ra);
        logic [31:0] want;
        @(negedge clk);
        oper = op; addr_w = aw; data_w = dw; addr_r = ar;
        ir_en = en; ir_in = lines; ret_addr = ra;
        want = modelRead(ar);
        stepModel(op, aw, dw, en, lines, ra);
        #1;
        checkOutput("data_r", data_r, want);
    endtask

    task automatic assertReset();
        rst = 1;
        modelReset();
        sb.delete();
    endtask

    task automatic releaseReset(input logic [N-1:0] lines);
        repeat (2) @(negedge clk);
        oper = 0; addr_w = 0; data_w = 0; addr_r = 0; ir_en = 0; ret_addr = 0;
        ir_in = lines;
        rst = 0;
        stepModel(2'b00, 5'd0, 32'd0, 1'b0, lines, 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses jump_en
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) begin
                if (jump_en) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_jump: got jump_addr 0x%0h, want no jump", jump_addr);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("jump_cycle", 32'(cyc), 32'(e.cyc));
                        checkOutput("jump_addr", jump_addr, e.addr);
                        checkOutput("ir_pulse", 32'(ir), 32'(e.ir));
                    end
                end else begin
                    checkOutput("ir_idle", 32'(ir), 32'd0);
                    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                        e = sb.pop_front();
                        checks++; errors++;
                        $display("[TB] FAIL missing_jump: got no jump at cycle %0d, want jump_addr 0x%0h", cyc, e.addr);
                    end
                end
                checkOutput("ir_busy", 32'(ir_busy), 32'(m_exl));
                checkOutput("ir_pending", 32'(ir_pending), 32'(modelPending()));
            end
        end
    end

    initial begin
        logic [1:0]   op;
        logic [4:0]   aw, ar;
        logic [31:0]  dw;
        logic [N-1:0] lines;
        int           r;

        oper = 0; addr_r = 0; addr_w = 0; data_w = 0; ir_en = 0; ir_in = 0; ret_addr = 0;
        assertReset();
        #1;
        checkOutput("rst_jump_en", 32'(jump_en), 32'd0);
        checkOutput("rst_ir", 32'(ir), 32'd0);
        addr_r = 12; #1 checkOutput("rst_status", data_r, 32'h0000_0F01);
        addr_r = 15; #1 checkOutput("rst_ehbr", data_r, EHBR_INIT);
        addr_r = 13; #1 checkOutput("rst_cause", data_r, 32'd0);
        releaseReset(4'b0000);

        // Non-vectored dispatch of line 2
        applyStimulus(2'b10, 15, 32'h100, 0, 1, 4'b0000, 0);
        applyStimulus(2'b00, 0, 0, 12, 1, 4'b0100, 32'h40);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b0100, 32'h40);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b0000, 32'h44);
        applyStimulus(2'b00, 0, 0, 14, 1, 4'b0000, 32'h44);
        applyStimulus(2'b11, 0, 0, 12, 1, 4'b0000, 0);

        // Vectored dispatch, simultaneous lines 1 and 3, serviced after ERET
        applyStimulus(2'b10, 12, 32'h0F05, 0, 1, 4'b0000, 0);
        applyStimulus(2'b10, 15, 32'h200, 0, 1, 4'b0000, 0);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b1010, 32'h80);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b1010, 32'h84);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b1010, 32'h88);
        applyStimulus(2'b11, 0, 0, 14, 1, 4'b0000, 32'h8C);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b0000, 32'h90);
        applyStimulus(2'b00, 0, 0, 14, 1, 4'b0000, 32'h94);
        applyStimulus(2'b11, 0, 0, 12, 1, 4'b0000, 0);

        // Masked line 0 stays pending until write-one-to-clear
        applyStimulus(2'b10, 12, 32'h0E01, 0, 1, 4'b0000, 0);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b0001, 32'hA0);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b0001, 32'hA4);
        applyStimulus(2'b10, 13, 32'h100, 13, 1, 4'b0000, 32'hA8);
        applyStimulus(2'b00, 0, 0, 13, 1, 4'b0000, 32'hAC);
        applyStimulus(2'b10, 12, 32'h0F01, 12, 1, 4'b0000, 0);

        // Line held high through reset release registers an edge immediately
        assertReset();
        releaseReset(4'b0001);
        lines = 4'b0001;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 6) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            aw = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ar = ($urandom_range(0, 1) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            dw = $urandom;
            if (aw == 12) begin
                if ($urandom_range(0, 3) != 0) dw[0] = 1'b1;
                if ($urandom_range(0, 3) != 0) dw[1] = 1'b0;
            end
            lines = lines ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            applyStimulus(op, aw, dw, ar, ($urandom_range(0, 3) != 0), lines, $urandom & ~32'h3);
        end

        // Asynchronous reset while the handler jump is in flight
        assertReset();
        releaseReset(4'b0000);
        applyStimulus(2'b00, 0, 0, 0, 0, 4'b0001, 0);
        applyStimulus(2'b00, 0, 0, 0, 1, 4'b0001, 32'h1234);
        @(posedge clk);
        #2;
        checkOutput("pre_rst_jump_en", 32'(jump_en), 32'd1);
        checkOutput("pre_rst_busy", 32'(ir_busy), 32'd1);
        assertReset();
        addr_r = 14;
        #1;
        checkOutput("async_jump_en", 32'(jump_en), 32'd0);
        checkOutput("async_jump_addr", jump_addr, 32'd0);
        checkOutput("async_ir", 32'(ir), 32'd0);
        checkOutput("async_busy", 32'(ir_busy), 32'd0);
        checkOutput("async_pending", 32'(ir_pending), 32'd0);
        checkOutput("async_epc", data_r, 32'd0);
        addr_r = 12; #1 checkOutput("async_status", data_r, 32'h0000_0F01);
        releaseReset(4'b0000);

        repeat (4) applyStimulus(2'b00, 0, 0, 13, 0, 4'b0000, 0);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
